// File: rtl/program_memory_unit_if.sv
// rtl/program_memory_unit_if.sv - CPU memory port and byte-stream loader bundle for program_memory_unit
//
// Purpose: groups the CPU memory port (address/rw_flag/write/read data) and the
// loader stream (load_valid/load_data/load_last/load_ready) with the boot status
// signals (reload_request, cpu_hold, load_done, load_count).
// Modports:
//   master - CPU core and loader source side (drives address, rw_flag,
//            write_memory_value, load_valid, load_data, load_last, reload_request)
//   slave  - memory side (drives read_memory_value, load_ready, cpu_hold,
//            load_done, load_count)
// rw_flag encoding: 2'b00 MEMORY_STAY, 2'b01 MEMORY_READ, 2'b10 MEMORY_WRITE.
interface program_memory_unit_if #(
    parameter int REGSIZE = 8
);
    logic [REGSIZE-1:0] address;
    logic [1:0]         rw_flag;
    logic [REGSIZE-1:0] write_memory_value;
    logic [REGSIZE-1:0] read_memory_value;
    logic               load_valid;
    logic [REGSIZE-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic               reload_request;
    logic               cpu_hold;
    logic               load_done;
    logic [REGSIZE:0]   load_count;

    modport master (
        output address, rw_flag, write_memory_value,
        output load_valid, load_data, load_last, reload_request,
        input  read_memory_value, load_ready, cpu_hold, load_done, load_count
    );

    modport slave (
        input  address, rw_flag, write_memory_value,
        input  load_valid, load_data, load_last, reload_request,
        output read_memory_value, load_ready, cpu_hold, load_done, load_count
    );
endinterface

// File: rtl/program_memory_unit.sv
// rtl/program_memory_unit.sv - unified program/data memory with boot-time byte-stream loader
//
// Purpose: one memory array shared by a byte-stream loader and the CPU memory
// port. A boot state machine (BOOT -> LOAD -> RELEASE -> RUN) grants the array
// to the loader until the image is complete, holding the CPU in reset, then
// hands it to the CPU. A reload_request pulse in RUN restarts the sequence.
// Ports:
//   i_clk - system clock, all state on the rising edge
//   i_rst - asynchronous active-high reset
//   bus   - program_memory_unit_if.slave (CPU port, loader stream, status)
module program_memory_unit #(
    parameter int REGSIZE = 8,
    parameter int DEPTH   = 2**REGSIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    program_memory_unit_if.slave  bus
);
    localparam logic [1:0] MEMORY_READ  = 2'b01;
    localparam logic [1:0] MEMORY_WRITE = 2'b10;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [REGSIZE-1:0] r_mem [DEPTH];
    logic [REGSIZE-1:0] r_load_ptr;
    logic [REGSIZE:0]   r_load_count;
    logic [REGSIZE-1:0] r_read_hold;

    logic w_run;
    logic w_accept;
    logic w_load_end;
    logic w_cpu_read;
    logic w_cpu_write;

    assign w_run       = (r_state == RUN);
    assign w_accept    = (r_state == LOAD) && bus.load_valid;
    // The address space is fully decoded, so the top address is all ones.
    assign w_load_end  = w_accept && (bus.load_last || (&r_load_ptr));
    assign w_cpu_read  = w_run && (bus.rw_flag == MEMORY_READ);
    assign w_cpu_write = w_run && (bus.rw_flag == MEMORY_WRITE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = LOAD;
            LOAD:    if (w_load_end) w_next_state = RELEASE;
            RELEASE: w_next_state = RUN;
            RUN:     if (bus.reload_request) w_next_state = BOOT;
            default: w_next_state = BOOT;
        endcase
    end

    // The pointer wraps naturally after the top address; the count is one bit
    // wider so a full image reports DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load_ptr   <= '0;
            r_load_count <= '0;
        end else if (r_state == BOOT) begin
            r_load_ptr   <= '0;
            r_load_count <= '0;
        end else if (w_accept) begin
            r_load_ptr   <= r_load_ptr + REGSIZE'(1);
            r_load_count <= r_load_count + (REGSIZE+1)'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_read_hold <= '0;
        end else if (w_cpu_read) begin
            r_read_hold <= r_mem[bus.address];
        end
    end

    // The array is deliberately not reset: contents survive reset and reload.
    // Loader and CPU writes are mutually exclusive by state.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_load_ptr] <= bus.load_data;
        end else if (w_cpu_write) begin
            r_mem[bus.address] <= bus.write_memory_value;
        end
    end

    assign bus.load_ready        = (r_state == LOAD);
    assign bus.cpu_hold          = !w_run;
    assign bus.load_done         = w_run;
    assign bus.load_count        = r_load_count;
    assign bus.read_memory_value = !w_run      ? '0 :
                                   w_cpu_read  ? r_mem[bus.address] :
                                                 r_read_hold;
endmodule

// File: tb/tb_program_memory_unit.sv
// tb/tb_program_memory_unit.sv - self-checking bench for program_memory_unit
module tb_program_memory_unit;
    localparam int REGSIZE = 8;
    localparam logic [1:0] MEMORY_STAY  = 2'b00;
    localparam logic [1:0] MEMORY_READ  = 2'b01;
    localparam logic [1:0] MEMORY_WRITE = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_memory_unit_if #(.REGSIZE(REGSIZE)) bus();

    program_memory_unit #(.REGSIZE(REGSIZE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem   [256];
    bit         ref_known [256];
    logic [7:0] exp_hold;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end

    task automatic wait_for_load(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.load_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s wait_load: load_ready=%0b after 8 cycles, required 1", tag, bus.load_ready);
        end
    endtask

    // gap_mode < 0: fixed gap of -gap_mode idle cycles before every byte after the first;
    // gap_mode >= 0: random gap of 0..gap_mode idle cycles.
    task automatic load_stream(input logic [7:0] data[$], input bit use_last, input int gap_mode, input string tag);
        int n = data.size();
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (i == 0) ? 0 : (gap_mode < 0 ? -gap_mode : int'($urandom_range(0, gap_mode)));
            repeat (gap) begin
                bus.load_valid = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.load_ready !== 1'b1 || bus.read_memory_value !== 8'h00) begin
                    errors++;
                    $display("FAIL %s gap: load_ready=%0b read=%02h, required 1 and 00", tag, bus.load_ready, bus.read_memory_value);
                end
                @(posedge clk); #1;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = data[i];
            bus.load_last  = use_last && (i == n - 1);
            @(negedge clk);
            checks++;
            if (bus.load_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.read_memory_value !== 8'h00) begin
                errors++;
                $display("FAIL %s byte%0d: ready=%0b hold=%0b read=%02h, required 1 1 00", tag, i, bus.load_ready, bus.cpu_hold, bus.read_memory_value);
            end
            @(posedge clk);
            ref_mem[i]   = data[i];
            ref_known[i] = 1'b1;
            #1;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.rw_flag    = MEMORY_STAY;
        @(negedge clk);
        checks++;
        if (bus.cpu_hold !== 1'b1 || bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL %s release: hold=%0b ready=%0b done=%0b, required 1 0 0", tag, bus.cpu_hold, bus.load_ready, bus.load_done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.cpu_hold !== 1'b0 || bus.load_done !== 1'b1 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s run: hold=%0b done=%0b ready=%0b, required 0 1 0", tag, bus.cpu_hold, bus.load_done, bus.load_ready);
        end
        checks++;
        if (bus.load_count !== 9'(n)) begin
            errors++;
            $display("FAIL %s load_count: got %0d, required %0d", tag, bus.load_count, n);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.rw_flag = MEMORY_WRITE; bus.write_memory_value = d;
        @(negedge clk);
        checks++;
        if (bus.read_memory_value !== exp_hold) begin
            errors++;
            $display("FAIL write_hold @%02h: read=%02h, required %02h", a, bus.read_memory_value, exp_hold);
        end
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        @(posedge clk); #1;
        bus.address = a; bus.rw_flag = MEMORY_READ;
        @(negedge clk);
        checks++;
        if (bus.read_memory_value !== ref_mem[a]) begin
            errors++;
            $display("FAIL read @%02h: got %02h, required %02h", a, bus.read_memory_value, ref_mem[a]);
        end
        exp_hold = ref_mem[a];
    endtask

    task automatic cpu_stay();
        @(posedge clk); #1;
        bus.rw_flag = MEMORY_STAY;
        @(negedge clk);
        checks++;
        if (bus.read_memory_value !== exp_hold) begin
            errors++;
            $display("FAIL stay: read=%02h, required %02h", bus.read_memory_value, exp_hold);
        end
    endtask

    task automatic do_reload();
        @(posedge clk); #1;
        bus.reload_request = 1'b1;
        @(posedge clk); #1;
        bus.reload_request = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.address = '0; bus.rw_flag = MEMORY_STAY; bus.write_memory_value = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0; bus.reload_request = 1'b0;
        exp_hold = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset load_ready: got %0b, required 0", bus.load_ready); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL reset cpu_hold: got %0b, required 1", bus.cpu_hold); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset load_done: got %0b, required 0", bus.load_done); end
        checks++; if (bus.load_count !== 9'd0) begin errors++; $display("FAIL reset load_count: got %0d, required 0", bus.load_count); end
        checks++; if (bus.read_memory_value !== 8'h00) begin errors++; $display("FAIL reset read: got %02h, required 00", bus.read_memory_value); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL boot load_ready: got %0b, required 0", bus.load_ready); end
        @(posedge clk); #1;
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL first_load load_ready: got %0b, required 1", bus.load_ready); end
    endtask

    task automatic test_load_basic();
        logic [7:0] q[$];
        q.push_back(8'h03); q.push_back(8'h1F); q.push_back(8'hF0);
        load_stream(q, 1'b1, 0, "basic");
        for (int i = 0; i < 3; i++) cpu_read(8'(i));
    endtask

    task automatic test_cpu_rw();
        logic [7:0] a;
        cpu_write(8'h80, 8'h5A);
        cpu_read(8'h80);
        cpu_stay();
        cpu_stay();
        checks++;
        if (bus.read_memory_value !== 8'h5A) begin
            errors++;
            $display("FAIL stay_5a: got %02h, required 5a", bus.read_memory_value);
        end
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: cpu_write(8'($urandom_range(8'h90, 8'hFF)), 8'($urandom));
                1: begin
                    a = 8'($urandom);
                    if (ref_known[a]) cpu_read(a); else cpu_read(8'h80);
                end
                default: cpu_stay();
            endcase
        end
        cpu_stay();
    endtask

    task automatic test_reload_blocked();
        logic [7:0] q[$];
        logic [7:0] d = 8'($urandom);
        @(posedge clk); #1;
        bus.reload_request = 1'b1;
        bus.address = 8'h40; bus.rw_flag = MEMORY_WRITE; bus.write_memory_value = d;
        @(negedge clk);
        checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_pre hold: got %0b, required 0", bus.cpu_hold); end
        @(posedge clk);
        ref_mem[8'h40] = d; ref_known[8'h40] = 1'b1;
        #1;
        bus.reload_request = 1'b0;
        bus.address = 8'h80; bus.write_memory_value = 8'h77;
        @(negedge clk);
        checks++;
        if (bus.cpu_hold !== 1'b1 || bus.load_ready !== 1'b0 || bus.read_memory_value !== 8'h00) begin
            errors++;
            $display("FAIL reload_boot: hold=%0b ready=%0b read=%02h, required 1 0 00", bus.cpu_hold, bus.load_ready, bus.read_memory_value);
        end
        wait_for_load("reload");
        q.push_back(8'hAA); q.push_back(8'hBB);
        load_stream(q, 1'b1, -2, "gap");
        cpu_read(8'h00);
        cpu_read(8'h01);
        cpu_read(8'h02);
        cpu_read(8'h40);
        cpu_read(8'h80);
    endtask

    task automatic test_random_load();
        logic [7:0] q[$];
        int n;
        for (int r = 0; r < 3; r++) begin
            q.delete();
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_reload();
            wait_for_load("rand");
            load_stream(q, 1'b1, 3, "rand");
            for (int i = 0; i < n; i++) cpu_read(8'(i));
            cpu_stay();
        end
    endtask

    task automatic test_full_stream();
        logic [7:0] q[$];
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        do_reload();
        wait_for_load("full");
        load_stream(q, 1'b0, 0, "full");
        cpu_read(8'hFF);
        checks++; if (bus.read_memory_value !== 8'hFF) begin errors++; $display("FAIL full_last: got %02h, required ff", bus.read_memory_value); end
        cpu_read(8'h00);
        for (int i = 0; i < 8; i++) cpu_read(8'($urandom));
        cpu_stay();
    endtask

    task automatic test_reset_midload();
        logic [7:0] q[$];
        do_reload();
        wait_for_load("midload");
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1; bus.load_data = 8'($urandom); bus.load_last = 1'b0;
            @(posedge clk);
            ref_mem[i] = bus.load_data;
            #1;
        end
        bus.load_data = 8'($urandom);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.load_ready !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset flags: ready=%0b hold=%0b done=%0b, required 0 1 0", bus.load_ready, bus.cpu_hold, bus.load_done);
        end
        checks++;
        if (bus.load_count !== 9'd0 || bus.read_memory_value !== 8'h00) begin
            errors++;
            $display("FAIL midreset values: count=%0d read=%02h, required 0 00", bus.load_count, bus.read_memory_value);
        end
        exp_hold = 8'h00;
        bus.load_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_for_load("after_reset");
        q.push_back(8'h11); q.push_back(8'h22);
        load_stream(q, 1'b1, 0, "reload2");
        cpu_stay();
        cpu_read(8'h00);
        cpu_read(8'h01);
        cpu_read(8'h02);
        cpu_stay();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_load_basic();
        test_cpu_rw();
        test_reload_blocked();
        test_random_load();
        test_full_stream();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
